// File: rtl/spk_train_packer.sv
// Collects per-group FC output spikes for one image, then writes them time-major
// into the next layer's spike RAM as FRAME_SIZE-bit words and raises ram_loaded.
module spk_train_packer #(
  parameter int TIME_STEPS     = 10,
  parameter int EC_SIZE        = 4,
  parameter int LAYER_SIZE     = 32,
  parameter int FRAME_SIZE     = 120,
  parameter int CH             = (LAYER_SIZE + FRAME_SIZE - 1) / FRAME_SIZE,
  parameter int RAM_ADDR_WIDTH = $clog2(TIME_STEPS * CH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       spk_valid,
  input  logic [EC_SIZE-1:0]                         spk_in,
  input  logic [$clog2(LAYER_SIZE/EC_SIZE):0]        neuron_grp,
  input  logic [$clog2(TIME_STEPS):0]                time_step,
  input  logic                                       layer_done,
  output logic                                       ram_we,
  output logic [RAM_ADDR_WIDTH-1:0]                  ram_addr,
  output logic [FRAME_SIZE-1:0]                      ram_wdata,
  output logic                                       ram_loaded,
  output logic [$clog2(LAYER_SIZE*TIME_STEPS+1)-1:0] total_spks,
  output logic                                       err_drop
);

  localparam int NGRP      = LAYER_SIZE / EC_SIZE;
  localparam int NWORDS    = TIME_STEPS * CH;
  localparam int WORD_BITS = CH * FRAME_SIZE;
  localparam int GW        = $clog2(NGRP) + 1;
  localparam int TSW       = $clog2(TIME_STEPS) + 1;
  localparam int TOT_W     = $clog2(LAYER_SIZE * TIME_STEPS + 1);
  localparam int W_W       = $clog2(NWORDS + 1);
  localparam int TI_W      = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1;
  localparam int CI_W      = (CH > 1) ? $clog2(CH) : 1;
  localparam int POP_W     = $clog2(EC_SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_LOADED} state_e;

  state_e                    state_q;
  logic [WORD_BITS-1:0]      buf_q [TIME_STEPS];
  logic [WORD_BITS-1:0]      buf_d [TIME_STEPS];
  logic [W_W-1:0]            w_q;
  logic [TI_W-1:0]           rd_t_q;
  logic [CI_W-1:0]           rd_c_q;
  logic                      ram_we_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
  logic [FRAME_SIZE-1:0]     ram_wdata_q;
  logic                      ram_loaded_q;
  logic [TOT_W-1:0]          total_q;
  logic                      err_q;

  logic                      vec_ok;
  logic [POP_W-1:0]          pop;
  logic [TOT_W:0]            total_sum;
  logic [TOT_W-1:0]          total_d;
  logic [FRAME_SIZE-1:0]     rd_word;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    vec_ok = (time_step < TSW'(TIME_STEPS)) && (neuron_grp < GW'(NGRP));

    pop = '0;
    for (int k = 0; k < EC_SIZE; k++) begin
      pop = pop + POP_W'(spk_in[k]);
    end
    total_sum = {1'b0, total_q} + (TOT_W+1)'(pop);
    total_d   = total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];

    // Neuron n lives at flat bit n, i.e. word n/FRAME_SIZE, bit n%FRAME_SIZE.
    buf_d = buf_q;
    for (int t = 0; t < TIME_STEPS; t++) begin
      for (int n = 0; n < LAYER_SIZE; n++) begin
        if (time_step == TSW'(t) && neuron_grp == GW'(n / EC_SIZE)) begin
          buf_d[t][n] = buf_q[t][n] | spk_in[n % EC_SIZE];
        end
      end
    end

    rd_word = '0;
    for (int t = 0; t < TIME_STEPS; t++) begin
      for (int c = 0; c < CH; c++) begin
        if (rd_t_q == TI_W'(t) && rd_c_q == CI_W'(c)) begin
          rd_word = buf_q[t][c*FRAME_SIZE +: FRAME_SIZE];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      // NOTE: the buffer is reset so an abandoned image can never leak bits into the next one.
      buf_q        <= '{default: '0};
      w_q          <= '0;
      rd_t_q       <= '0;
      rd_c_q       <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_loaded_q <= 1'b0;
      total_q      <= '0;
      err_q        <= 1'b0;
    end else if (start) begin
      state_q      <= S_COLLECT;
      buf_q        <= '{default: '0};
      w_q          <= '0;
      rd_t_q       <= '0;
      rd_c_q       <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_loaded_q <= 1'b0;
      total_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (spk_valid) err_q <= 1'b1;
        end

        S_COLLECT: begin
          if (spk_valid) begin
            if (vec_ok) begin
              buf_q   <= buf_d;
              total_q <= total_d;
            end else begin
              err_q <= 1'b1;
            end
          end
          if (layer_done) begin
            state_q <= S_FLUSH;
            w_q     <= '0;
            rd_t_q  <= '0;
            rd_c_q  <= '0;
          end
        end

        S_FLUSH: begin
          if (spk_valid) err_q <= 1'b1;
          ram_we_q    <= 1'b1;
          ram_addr_q  <= w_q[RAM_ADDR_WIDTH-1:0];
          ram_wdata_q <= rd_word;
          w_q         <= w_q + 1'b1;
          if (rd_c_q == CI_W'(CH - 1)) begin
            rd_c_q <= '0;
            rd_t_q <= rd_t_q + 1'b1;
          end else begin
            rd_c_q <= rd_c_q + 1'b1;
          end
          // The last word is issued on this edge; ram_loaded follows one cycle later.
          if (w_q == W_W'(NWORDS - 1)) state_q <= S_LOADED;
        end

        S_LOADED: begin
          if (spk_valid) err_q <= 1'b1;
          ram_we_q     <= 1'b0;
          ram_addr_q   <= '0;
          ram_wdata_q  <= '0;
          ram_loaded_q <= 1'b1;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_loaded = ram_loaded_q;
  assign total_spks = total_q;
  assign err_drop   = err_q;

endmodule

// File: tb/tb_spk_train_packer.sv
// Directed + randomized bench for spk_train_packer against a per-neuron spike-table model.
module tb_spk_train_packer;

  localparam int TS      = 10;
  localparam int EC      = 4;
  localparam int LS      = 32;
  localparam int FS      = 120;
  localparam int CH      = 1;
  localparam int AW      = 4;
  localparam int NG      = LS / EC;
  localparam int NW      = TS * CH;
  localparam int TW      = 9;
  localparam int TOT_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          spk_valid = 1'b0;
  logic [EC-1:0] spk_in = '0;
  logic [3:0]    neuron_grp = '0;
  logic [4:0]    time_step = '0;
  logic          layer_done = 1'b0;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [FS-1:0] ram_wdata;
  logic          ram_loaded;
  logic [TW-1:0] total_spks;
  logic          err_drop;

  spk_train_packer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .spk_valid  (spk_valid),
    .spk_in     (spk_in),
    .neuron_grp (neuron_grp),
    .time_step  (time_step),
    .layer_done (layer_done),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_loaded (ram_loaded),
    .total_spks (total_spks),
    .err_drop   (err_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one bit per (time step, neuron), plus counters.
  bit m_spk [TS][LS];
  int m_total;
  bit m_err;
  bit m_collect;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int t = 0; t < TS; t++)
      for (int n = 0; n < LS; n++) m_spk[t][n] = 1'b0;
    m_total = 0;
    m_err   = 1'b0;
  endtask

  function automatic logic [FS-1:0] model_word(input int w);
    logic [FS-1:0] word;
    int t, c, n;
    word = '0;
    t = w / CH;
    c = w % CH;
    for (int b = 0; b < FS; b++) begin
      n = c * FS + b;
      if (n < LS) word[b] = m_spk[t][n];
    end
    return word;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_total"}, total_spks, m_total);
    check({tag, "_err"}, err_drop, m_err);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    m_collect = 1'b1;
  endtask

  task automatic send(input int grp, input int t, input logic [EC-1:0] vec, input bit ld);
    spk_valid  = 1'b1;
    neuron_grp = 4'(grp);
    time_step  = 5'(t);
    spk_in     = vec;
    layer_done = ld;
    tick();
    spk_valid  = 1'b0;
    layer_done = 1'b0;
    spk_in     = '0;
    if (m_collect && t < TS && grp < NG) begin
      for (int k = 0; k < EC; k++)
        if (vec[k]) m_spk[t][grp*EC+k] = 1'b1;
      m_total = m_total + $countones(vec);
      if (m_total > TOT_MAX) m_total = TOT_MAX;
    end else begin
      m_err = 1'b1;
    end
    if (ld && m_collect) m_collect = 1'b0;
  endtask

  task automatic flush(input bit ld_sent, input string tag);
    int nwr;
    int first;
    int loaded_at;
    bit overlap;
    nwr = 0;
    first = -1;
    loaded_at = -1;
    overlap = 1'b0;
    if (!ld_sent) begin
      layer_done = 1'b1;
      tick();
      layer_done = 1'b0;
      m_collect = 1'b0;
    end
    for (int i = 1; i <= 40 && loaded_at < 0; i++) begin
      tick();
      if (ram_we && ram_loaded) overlap = 1'b1;
      if (ram_we) begin
        if (first < 0) first = i;
        check({tag, "_addr"}, ram_addr, nwr);
        check({tag, "_word"}, ram_wdata, model_word(nwr));
        nwr++;
      end
      if (ram_loaded) loaded_at = i;
    end
    check({tag, "_first_we"}, first, 1);
    check({tag, "_nwrites"}, nwr, NW);
    check({tag, "_loaded_at"}, loaded_at, NW + 1);
    check({tag, "_overlap"}, overlap, 1'b0);
    tick();
    check({tag, "_loaded_hold"}, {ram_loaded, ram_we}, 2'b10);
    check_counts(tag);
  endtask

  initial begin
    int grp, t;
    bit found;
    model_clear();
    m_collect = 1'b0;

    // Reset values
    tick();
    check("rst_we", ram_we, 1'b0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_loaded", ram_loaded, 1'b0);
    check_counts("rst");
    rst = 1'b1;
    tick();

    // spk_valid and layer_done in IDLE
    send(0, 0, 4'hF, 1'b1);
    check_counts("idle_valid");
    check("idle_ld_we", ram_we, 1'b0);

    // Directed image: two vectors
    do_start();
    check_counts("start1");
    send(0, 0, 4'b1010, 1'b0);
    send(7, 9, 4'b0001, 1'b0);
    check_counts("img1");
    flush(1'b0, "img1");

    // spk_valid in LOADED sets err_drop; start clears it and drops ram_loaded
    send(1, 1, 4'b0110, 1'b0);
    check_counts("loaded_valid");
    do_start();
    check("restart_loaded", ram_loaded, 1'b0);
    check_counts("restart");

    // All-ones across every group and step
    for (int tt = 0; tt < TS; tt++)
      for (int g = 0; g < NG; g++) send(g, tt, 4'hF, 1'b0);
    check_counts("ones");
    flush(1'b0, "ones");

    // Illegal indices are dropped whole; buffer unchanged
    do_start();
    send(2, 3, 4'b0100, 1'b0);
    send(0, 10, 4'hF, 1'b0);
    send(8, 0, 4'hF, 1'b0);
    check_counts("drop");
    flush(1'b0, "drop");

    // spk_valid coincident with layer_done is captured before the flush
    do_start();
    send(3, 5, 4'hF, 1'b1);
    flush(1'b1, "same_cycle");

    // Empty image after restart from LOADED
    do_start();
    flush(1'b0, "empty");

    // Saturation of total_spks
    do_start();
    for (int i = 0; i < 130; i++) send(i % NG, i % TS, 4'hF, 1'b0);
    check_counts("sat");
    flush(1'b0, "sat");

    // Randomized images with occasional illegal indices and idle gaps
    for (int img = 0; img < 3; img++) begin
      do_start();
      for (int i = 0; i < 30; i++) begin
        grp = ($urandom_range(0, 15) == 0) ? 8 + $urandom_range(0, 7) : $urandom_range(0, NG - 1);
        t   = ($urandom_range(0, 15) == 0) ? 10 + $urandom_range(0, 21) : $urandom_range(0, TS - 1);
        send(grp, t, 4'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) tick();
      end
      check_counts("rand_pre");
      flush(1'b0, "rand");
    end

    // Reset in the middle of a flush
    do_start();
    send(4, 2, 4'b1001, 1'b0);
    layer_done = 1'b1;
    tick();
    layer_done = 1'b0;
    m_collect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ram_we && ram_addr == 4'd3) found = 1'b1;
    end
    check("midrst_reach_w3", found, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_we", ram_we, 1'b0);
    check("midrst_loaded", ram_loaded, 1'b0);
    check("midrst_total", total_spks, 0);
    model_clear();
    tick();
    rst = 1'b1;
    tick();
    do_start();
    send(6, 7, 4'b0010, 1'b0);
    flush(1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spk_train_packer.md
# spk_train_packer

Post-synaptic spike collector for the sparse FC pipeline. It captures the per-neuron output spikes produced by an FC engine (EC_SIZE neurons per group, group-outer/time-step-inner order) and buffers a full image's worth. It then writes them time-major into the next layer's spike RAM as FRAME_SIZE-bit words, one per (time step, channel), which is the layout the next layer's compressor reads. Completion is signalled with `ram_loaded`, which drives the next layer's `pre_syn_RAM_loaded`.

## Interface
- TIME_STEPS, 10, time steps per image
- EC_SIZE, 4, neurons evaluated in parallel per group
- LAYER_SIZE, 32, neurons in this layer (multiple of EC_SIZE)
- FRAME_SIZE, 120, RAM word width in bits
- CH, (LAYER_SIZE+FRAME_SIZE-1)/FRAME_SIZE, words per time step
- RAM_ADDR_WIDTH, $clog2(TIME_STEPS*CH), RAM address width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin new image, clear buffer
- spk_valid  in  1  spike vector valid this cycle
- spk_in  in  EC_SIZE  spike bits; bit k = neuron neuron_grp*EC_SIZE+k
- neuron_grp  in  $clog2(LAYER_SIZE/EC_SIZE)+1  group index
- time_step  in  $clog2(TIME_STEPS)+1  time step of spk_in
- layer_done  in  1  producer finished all groups; level or pulse
- ram_we  out  1  write strobe
- ram_addr  out  RAM_ADDR_WIDTH  = t*CH + c
- ram_wdata  out  FRAME_SIZE  packed spike word
- ram_loaded  out  1  RAM image complete (level)
- total_spks  out  $clog2(LAYER_SIZE*TIME_STEPS+1)  spikes captured this image
- err_drop  out  1  sticky: a spk_valid was discarded

## Operation
- Buffer: TIME_STEPS x CH*FRAME_SIZE bits. Neuron n, step t maps to bit n%FRAME_SIZE of word c=n/FRAME_SIZE. Padding bits ≥LAYER_SIZE are always 0.
- States: IDLE, COLLECT, FLUSH, LOADED.
- IDLE: outputs quiescent. `start` -> clear buffer, total_spks, and err_drop -> COLLECT.
- COLLECT: on spk_valid, OR spk_in into buffer[time_step] at base neuron_grp*EC_SIZE. total_spks += popcount(spk_in). If time_step ≥ TIME_STEPS or neuron_grp ≥ LAYER_SIZE/EC_SIZE, discard the whole vector and set err_drop. `layer_done` -> FLUSH with word counter w=0. A spk_valid in the same cycle is captured before the flush.
- FLUSH: each cycle ram_we=1, ram_addr=w, ram_wdata=buffer word (t=w/CH, c=w%CH), w++. After w=TIME_STEPS*CH-1 -> LOADED.
- LOADED: ram_loaded=1 held until `start`.
- spk_valid in IDLE/FLUSH/LOADED: ignored; err_drop set.
- `start` in any state: abandon the current image, clear, -> COLLECT. An in-progress flush is truncated and ram_loaded drops.
- Arithmetic: total_spks saturates at its maximum. w is sized $clog2(TIME_STEPS*CH+1) with no wrap.

## Timing
- Reset (async, rst=0): state IDLE. ram_we=0, ram_addr=0, ram_wdata=0, ram_loaded=0, total_spks=0, err_drop=0, buffer cleared. Release is synchronous to clk.
- Capture latency: spike on edge k is in the buffer and total_spks after edge k.
- layer_done sampled on edge k -> first ram_we on the cycle after edge k+1. Registered outputs: addr 0 is valid during cycle k+1..k+2.
- Flush is exactly TIME_STEPS*CH consecutive ram_we cycles, no stalls. ram_loaded rises on the cycle after the last write and never overlaps ram_we.
- start -> COLLECT on the next edge. ram_loaded is low from that edge.
- layer_done outside COLLECT is ignored.

## Test plan
- Reset mid-FLUSH (rst low at w=3) -> ram_we=0, ram_loaded=0, total_spks=0 immediately. Next image has no stale bits.
- Defaults; start; grp0 t0 spk_in=4'b1010; grp7 t9 spk_in=4'b0001; layer_done -> 10 writes, addr 0..9. Word0=…0_1010 (bits1,3). Word9 bit28 set. Others 0. total_spks=3. ram_loaded after write 9.
- All-ones every grp/t (80 vectors) -> each word = 32 low ones, bits 32..119 zero. total_spks=320.
- time_step=10 or neuron_grp=8 with spk_valid -> vector dropped, err_drop=1, buffer unchanged.
- spk_valid and layer_done same cycle (grp3 t5 4'b1111) -> word5 bits12–15 set in the flush.
- LOADED then start -> ram_loaded drops next edge, buffer/err_drop cleared. Second image with no spikes flushes all-zero words.
